// File: rtl/tftp_req_parser_if.sv
// Stream, mode-decoder and result signals of the TFTP request parser.
// master = payload source / decoder side, slave = the parser.
interface tftp_req_parser_if #(
  parameter int FNAME_AW = 6
);
  logic [7:0]        eth_data;
  logic              data_valid;
  logic              frame_start;
  logic              frame_end;
  logic              mode_clr;
  logic              mode_en;
  logic              mode_valid;
  logic              fname_we;
  logic [FNAME_AW-1:0] fname_addr;
  logic [7:0]        fname_data;
  logic [FNAME_AW:0] fname_len;
  logic              req_valid;
  logic              req_is_write;
  logic              req_error;
  logic [2:0]        err_code;

  modport master (
    output eth_data, data_valid, frame_start, frame_end, mode_valid,
    input  mode_clr, mode_en, fname_we, fname_addr, fname_data, fname_len,
           req_valid, req_is_write, req_error, err_code
  );

  modport slave (
    input  eth_data, data_valid, frame_start, frame_end, mode_valid,
    output mode_clr, mode_en, fname_we, fname_addr, fname_data, fname_len,
           req_valid, req_is_write, req_error, err_code
  );
endinterface

// File: rtl/tftp_req_parser.sv
// Walks a TFTP RRQ/WRQ payload (opcode, filename, mode) and issues one accept or
// reject pulse per frame. Define TFTP_FNAME_CAPTURE_EN to drive the filename write port.
module tftp_req_parser #(
  parameter int FNAME_MAX = 64,
  parameter int FNAME_AW  = 6,
  parameter int MODE_MAX  = 16
) (
  input  logic clk,
  input  logic reset,
  tftp_req_parser_if.slave bus
);
  localparam int MCW = $clog2(MODE_MAX + 1);
  localparam logic [FNAME_AW:0] FN_LIM = (FNAME_AW+1)'(FNAME_MAX);
  localparam logic [MCW-1:0]    MD_LIM = MCW'(MODE_MAX);

  typedef enum logic [2:0] {IDLE, OP_LO, FNAME, MODE, CHECK, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [FNAME_AW:0] fcnt, fcnt_nxt;
  logic [FNAME_AW:0] flen_q, flen_nxt;
  logic [MCW-1:0]    mcnt, mcnt_nxt;
  logic              wr_q, wr_nxt;
  logic [2:0]        ecode_q, ecode_nxt;
  logic              err_q;
  logic              chk_end, chk_end_nxt;
  logic [2:0]        err_set;
  logic              chk_ok, chk_bad, men;
  logic              start_v, end_v, is_nul;

  assign start_v = bus.data_valid & bus.frame_start;
  assign end_v   = bus.data_valid & bus.frame_end;
  assign is_nul  = (bus.eth_data == 8'h00);

  always_comb begin
    state_nxt   = state;
    fcnt_nxt    = fcnt;
    flen_nxt    = flen_q;
    mcnt_nxt    = mcnt;
    wr_nxt      = wr_q;
    ecode_nxt   = ecode_q;
    chk_end_nxt = 1'b0;
    err_set     = 3'd0;
    chk_ok      = 1'b0;
    chk_bad     = 1'b0;
    men         = 1'b0;
    if (start_v) begin
      // a new frame always wins, whatever the old one was doing
      fcnt_nxt  = '0;
      flen_nxt  = '0;
      mcnt_nxt  = '0;
      wr_nxt    = 1'b0;
      ecode_nxt = 3'd0;
      if (!is_nul)    err_set = 3'd1;
      else if (end_v) err_set = 3'd5;
      else            state_nxt = OP_LO;
    end else begin
      case (state)
        OP_LO: if (bus.data_valid) begin
          if (bus.eth_data == 8'h01 || bus.eth_data == 8'h02) begin
            wr_nxt = (bus.eth_data == 8'h02);
            if (end_v) err_set = 3'd5;
            else       state_nxt = FNAME;
          end else begin
            err_set = 3'd1;
          end
        end
        FNAME: if (bus.data_valid) begin
          if (is_nul) begin
            if (fcnt == '0) err_set = 3'd2;
            else begin
              flen_nxt = fcnt;
              if (end_v) err_set = 3'd5;
              else       state_nxt = MODE;
            end
          end else if (fcnt == FN_LIM) begin
            err_set = 3'd2;
          end else begin
            fcnt_nxt = fcnt + 1'b1;
            if (end_v) err_set = 3'd5;
          end
        end
        MODE: if (bus.data_valid) begin
          men = 1'b1;
          if (is_nul) begin
            state_nxt   = CHECK;
            chk_end_nxt = end_v;
          end else if (mcnt == MD_LIM) begin
            err_set = 3'd3;
          end else begin
            mcnt_nxt = mcnt + 1'b1;
            if (end_v) err_set = 3'd5;
          end
        end
        CHECK: begin
          // decoder verdict is registered on the NUL edge, so it is ready here
          if (bus.mode_valid) chk_ok = 1'b1;
          else begin
            chk_bad   = 1'b1;
            ecode_nxt = 3'd4;
          end
          state_nxt = (chk_end || end_v) ? IDLE : DRAIN;
        end
        DRAIN: if (end_v) state_nxt = IDLE;
        default: ;
      endcase
    end
    if (err_set != 3'd0) begin
      ecode_nxt = err_set;
      state_nxt = end_v ? IDLE : DRAIN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      fcnt    <= '0;
      flen_q  <= '0;
      mcnt    <= '0;
      wr_q    <= 1'b0;
      ecode_q <= 3'd0;
      err_q   <= 1'b0;
      chk_end <= 1'b0;
    end else begin
      state   <= state_nxt;
      fcnt    <= fcnt_nxt;
      flen_q  <= flen_nxt;
      mcnt    <= mcnt_nxt;
      wr_q    <= wr_nxt;
      ecode_q <= ecode_nxt;
      err_q   <= (err_set != 3'd0);
      chk_end <= chk_end_nxt;
    end
  end

  assign bus.mode_clr     = start_v;
  assign bus.mode_en      = men;
  assign bus.fname_len    = flen_q;
  assign bus.req_is_write = wr_q;
  assign bus.req_valid    = chk_ok;
  assign bus.req_error    = err_q | chk_bad;
  assign bus.err_code     = chk_bad ? 3'd4 : ecode_q;

`ifdef TFTP_FNAME_CAPTURE_EN
  assign bus.fname_we   = (state == FNAME) && bus.data_valid && !bus.frame_start &&
                          !is_nul && (fcnt != FN_LIM);
  assign bus.fname_addr = fcnt[FNAME_AW-1:0];
  assign bus.fname_data = bus.eth_data;
`else
  assign bus.fname_we   = 1'b0;
  assign bus.fname_addr = '0;
  assign bus.fname_data = 8'h00;
`endif
endmodule

// File: tb/tb_tftp_req_parser.sv
// Bench for tftp_req_parser: directed vector table, hand-written abort/reset
// sequences, then random frames against a frame-level reference model.
module tb_tftp_req_parser;
  localparam int FNAME_MAX = 64;
  localparam int FNAME_AW  = 6;
  localparam int MODE_MAX  = 16;
`ifdef TFTP_FNAME_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tftp_req_parser_if #(.FNAME_AW(FNAME_AW)) bus ();
  tftp_req_parser #(.FNAME_MAX(FNAME_MAX), .FNAME_AW(FNAME_AW), .MODE_MAX(MODE_MAX))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit is_octet(input logic [39:0] s, input int n);
    logic [39:0] l;
    l = s;
    for (int k = 0; k < 5; k++)
      if (s[k*8 +: 8] >= 8'h41 && s[k*8 +: 8] <= 8'h5a) l[k*8 +: 8] = s[k*8 +: 8] | 8'h20;
    return (n == 5) && (l == 40'h6f63746574);
  endfunction

  // case-insensitive "octet" mode decoder stub with a registered verdict
  logic [39:0] mstr;
  int          mlen;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mstr <= '0; mlen <= 0; bus.mode_valid <= 1'b0;
    end else if (bus.mode_clr) begin
      mstr <= '0; mlen <= 0; bus.mode_valid <= 1'b0;
    end else if (bus.mode_en) begin
      if (bus.eth_data == 8'h00) bus.mode_valid <= is_octet(mstr, mlen);
      else begin
        mstr <= {mstr[31:0], bus.eth_data};
        mlen <= mlen + 1;
        bus.mode_valid <= 1'b0;
      end
    end
  end

  logic [7:0] fr[$];
  bit         fs_q[$], fe_q[$];
  int         bcyc[$];
  int         cur_idx = 0, fbase = 0;
  int         n_val, n_err, n_clr, n_we, we_bad, p_cyc, p_code;
  bit         p_wr;

  always @(negedge clk) begin
    if (bus.data_valid && bus.frame_start) begin fbase = cur_idx; n_we = 0; end
    if (bus.req_valid) n_val++;
    if (bus.req_error) n_err++;
    if (bus.req_valid || bus.req_error) begin
      p_cyc = cyc; p_code = int'(bus.err_code); p_wr = bus.req_is_write;
    end
    if (bus.mode_clr) n_clr++;
    if (bus.fname_we) begin
      if (int'(bus.fname_addr) != n_we) we_bad++;
      if (fbase + 2 + n_we >= fr.size()) we_bad++;
      else if (bus.fname_data != fr[fbase + 2 + n_we]) we_bad++;
      n_we++;
    end
  end

  task automatic clr_mon();
    n_val = 0; n_err = 0; n_clr = 0; n_we = 0; we_bad = 0;
    p_cyc = -100; p_code = -1; p_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.data_valid = 1'b0; bus.frame_start = 1'b0; bus.frame_end = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_byte(input int idx, input logic [7:0] b, input bit s, input bit e);
    cur_idx = idx; bus.eth_data = b; bus.data_valid = 1'b1;
    bus.frame_start = s; bus.frame_end = e;
    @(posedge clk); #1;
  endtask

  task automatic send(input bit gaps);
    bcyc.delete();
    for (int i = 0; i < fr.size(); i++) begin
      if (gaps && i > 0 && $urandom_range(3) == 0) idle(1 + int'($urandom_range(1)));
      bcyc.push_back(cyc);
      drive_byte(i, fr[i], fs_q[i], fe_q[i]);
    end
    idle(4);
  endtask

  task automatic mark();
    fs_q.delete(); fe_q.delete();
    for (int i = 0; i < fr.size(); i++) begin fs_q.push_back(i == 0); fe_q.push_back(i == fr.size() - 1); end
  endtask

  task automatic build(input logic [15:0] op, input int flen, input string mode,
                       input int nopt, input int cut, input bit rnd);
    fr.delete();
    fr.push_back(op[15:8]); fr.push_back(op[7:0]);
    for (int i = 0; i < flen; i++)
      fr.push_back(rnd ? 8'($urandom_range(1, 255)) : 8'h61 + 8'(i % 26));
    fr.push_back(8'h00);
    for (int i = 0; i < mode.len(); i++) fr.push_back(8'(mode[i]));
    fr.push_back(8'h00);
    for (int i = 0; i < nopt; i++) fr.push_back(8'($urandom));
    if (cut > 0) while (fr.size() > cut) void'(fr.pop_back());
    mark();
  endtask

  // Frame-level reference: locate the terminators, then apply the request rules.
  task automatic model(output bit ok, output int code, output int at, output bit wr,
                       output int len, output int nw);
    int n, nul1, nul2, ml;
    logic [39:0] ms;
    n = fr.size();
    ok = 1'b0; code = 0; at = 0; wr = 1'b0; len = 0; nw = 0;
    if (fr[0] != 8'h00) begin code = 1; return; end
    if (n == 1) begin code = 5; return; end
    if (fr[1] != 8'h01 && fr[1] != 8'h02) begin code = 1; at = 1; return; end
    wr = (fr[1] == 8'h02);
    if (n == 2) begin code = 5; at = 1; return; end
    nul1 = 2;
    while (nul1 < n && fr[nul1] != 8'h00) nul1++;
    if (nul1 == 2) begin code = 2; at = 2; return; end
    if (nul1 - 2 > FNAME_MAX) begin code = 2; at = 2 + FNAME_MAX; nw = FNAME_MAX; return; end
    nw = nul1 - 2;
    if (nul1 == n) begin code = 5; at = n - 1; return; end
    len = nul1 - 2;
    if (nul1 == n - 1) begin code = 5; at = nul1; return; end
    nul2 = nul1 + 1;
    while (nul2 < n && fr[nul2] != 8'h00) nul2++;
    ml = nul2 - nul1 - 1;
    if (ml > MODE_MAX) begin code = 3; at = nul1 + 1 + MODE_MAX; return; end
    if (nul2 == n) begin code = 5; at = n - 1; return; end
    at = nul2;
    ms = '0;
    for (int k = 0; k < ml && k < 5; k++) ms = {ms[31:0], fr[nul1 + 1 + k]};
    ok = is_octet(ms, ml);
    if (!ok) code = 4;
  endtask

  task automatic check_frame(input string t, input bit ok, input int code, input int at,
                             input bit wr, input int len, input int nw, input int nclr);
    chk({t, " pulse count"}, n_val + n_err, 1);
    chk({t, " req_valid"}, n_val, ok ? 1 : 0);
    chk({t, " err_code"}, p_code, code);
    chk({t, " pulse latency"}, p_cyc - bcyc[at], 1);
    chk({t, " req_is_write"}, int'(p_wr), int'(wr));
    chk({t, " fname_len"}, int'(bus.fname_len), len);
    chk({t, " fname writes"}, n_we, CAP ? nw : 0);
    chk({t, " write addr/data"}, we_bad, 0);
    chk({t, " mode_clr"}, n_clr, nclr);
  endtask

  typedef struct {
    logic [15:0] op;
    int flen, msel, nopt, cut;
    bit e_ok; int e_code, e_at; bit e_wr; int e_len, e_nw;
  } vec_t;

  initial begin
    vec_t  tbl[14];
    string modes[5];
    bit    ok, wr;
    int    code, at, len, nw;
    string m;

    modes[0] = "octet"; modes[1] = "OCTET"; modes[2] = "netascii";
    modes[3] = ""; modes[4] = "";
    for (int i = 0; i < 17; i++) modes[3] = {modes[3], "x"};
    for (int i = 0; i < 16; i++) modes[4] = {modes[4], "x"};
    //            op        flen msel nopt cut ok code at  wr len nw
    tbl[0]  = '{16'h0001,   5,  0,  0,  0, 1, 0, 13, 0,  5,  5};
    tbl[1]  = '{16'h0002,   1,  1,  4,  0, 1, 0,  9, 1,  1,  1};
    tbl[2]  = '{16'h0005,   5,  0,  0,  0, 0, 1,  1, 0,  0,  0};
    tbl[3]  = '{16'h0001,   3,  2,  0,  0, 0, 4, 14, 0,  3,  3};
    tbl[4]  = '{16'h0001,  70,  0,  0,  0, 0, 2, 66, 0,  0, 64};
    tbl[5]  = '{16'h0001,  10,  0,  0,  6, 0, 5,  5, 0,  0,  4};
    tbl[6]  = '{16'h0101,   3,  0,  0,  0, 0, 1,  0, 0,  0,  0};
    tbl[7]  = '{16'h0001,   0,  0,  0,  0, 0, 2,  2, 0,  0,  0};
    tbl[8]  = '{16'h0001,   2,  3,  0,  0, 0, 3, 21, 0,  2,  2};
    tbl[9]  = '{16'h0001,   2,  4,  0,  0, 0, 4, 21, 0,  2,  2};
    tbl[10] = '{16'h0001,   3,  0,  0,  1, 0, 5,  0, 0,  0,  0};
    tbl[11] = '{16'h0001,   2,  0,  0,  8, 0, 5,  7, 0,  2,  2};
    tbl[12] = '{16'h0002,  64,  0,  2,  0, 1, 0, 72, 1, 64, 64};
    tbl[13] = '{16'h0002,   3,  0,  0,  2, 0, 5,  1, 1,  0,  0};

    bus.eth_data = 8'h00; bus.data_valid = 1'b0; bus.frame_start = 1'b0; bus.frame_end = 1'b0;
    clr_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_valid", int'(bus.req_valid), 0);
    chk("reset req_error", int'(bus.req_error), 0);
    chk("reset err_code", int'(bus.err_code), 0);
    chk("reset fname_len", int'(bus.fname_len), 0);
    chk("reset req_is_write", int'(bus.req_is_write), 0);
    chk("reset fname_addr", int'(bus.fname_addr), 0);
    chk("reset strobes", int'({bus.mode_clr, bus.mode_en, bus.fname_we}), 0);
    reset = 1'b1;
    idle(2);

    for (int v = 0; v < 14; v++) begin
      build(tbl[v].op, tbl[v].flen, modes[tbl[v].msel], tbl[v].nopt, tbl[v].cut, 1'b0);
      clr_mon();
      send(1'b0);
      check_frame($sformatf("vec%0d", v), tbl[v].e_ok, tbl[v].e_code, tbl[v].e_at,
                  tbl[v].e_wr, tbl[v].e_len, tbl[v].e_nw, 1);
    end

    // new frame_start in the middle of the mode string aborts the old request
    build(16'h0001, 1, "oc", 0, 6, 1'b0);
    fr.push_back(8'h00); fr.push_back(8'h02); fr.push_back(8'h79); fr.push_back(8'h00);
    m = "octet";
    for (int i = 0; i < 5; i++) fr.push_back(8'(m[i]));
    fr.push_back(8'h00);
    mark();
    fs_q[6] = 1'b1;
    clr_mon();
    send(1'b0);
    check_frame("abort", 1'b1, 0, 15, 1'b1, 1, 1, 2);

    // reset mid-frame: remaining bytes are ignored until the next frame_start
    build(16'h0001, 2, "octet", 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) drive_byte(i, fr[i], i == 0, 1'b0);
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    clr_mon();
    for (int i = 4; i < fr.size(); i++) drive_byte(i, fr[i], 1'b0, i == fr.size() - 1);
    idle(4);
    chk("midreset pulses", n_val + n_err, 0);
    chk("midreset fname_len", int'(bus.fname_len), 0);
    chk("midreset writes", n_we, 0);
    clr_mon();
    send(1'b0);
    check_frame("after reset", 1'b1, 0, 10, 1'b0, 2, 2, 1);

    for (int k = 0; k < 200; k++) begin
      int r, flen, cut;
      logic [15:0] op;
      r = int'($urandom_range(99));
      op = {8'h00, 8'($urandom_range(1, 2))};
      if (r < 5) op[15:8] = 8'($urandom_range(1, 255));
      else if (r < 12) op[7:0] = 8'($urandom);
      flen = (r % 7 == 0) ? int'($urandom_range(60, 68)) :
             (r % 11 == 0) ? 0 : int'($urandom_range(1, 12));
      case ($urandom_range(6))
        0: m = "octet";
        1: m = "OCTET";
        2: m = "oCtEt";
        3: m = "netascii";
        4: m = "octe";
        default: begin
          m = "";
          for (int i = 0; i < int'($urandom_range(0, 20)); i++) m = {m, "q"};
        end
      endcase
      cut = ($urandom_range(9) == 0) ? int'($urandom_range(1, flen + 12)) : 0;
      build(op, flen, m, int'($urandom_range(0, 5)), cut, 1'b1);
      model(ok, code, at, wr, len, nw);
      clr_mon();
      send(1'b1);
      check_frame($sformatf("rnd%0d", k), ok, code, at, wr, len, nw, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
